router_pkt_tx: RTL and testbench

Packet transmitter for the 1x3 router input port. Takes a command (destination, length) plus a payload byte stream, buffers the whole payload, then drives the router's `data_in`/`pkt_valid` pins: header, payload and XOR parity byte. It stalls on the router's `busy` without bubbles. It sits in front of the router as the source end of the router packet protocol and is used both in SoC integration and as a synthesizable traffic generator.

---
 rtl/router_pkg.sv | 37 +++
 rtl/router_tx_buf.sv | 25 ++
 rtl/router_pkt_tx.sv | 204 ++++++++++++++++++++
 tb/tb_router_pkt_tx.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router packet transmitter: header field layout,
// length limit, illegal address code, FSM encoding and small byte helpers.
package router_pkg;

    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_LEN_MSB  = 7;

    localparam int MAX_LEN = 63;

    localparam logic [1:0] ADDR_ILLEGAL = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_HEADER  = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_PARITY  = 3'd4,
        ST_GAP     = 3'd5
    } tx_state_t;

    // Pack destination and length into the on-wire header byte.
    function automatic logic [7:0] make_header(input logic [1:0] addr, input logic [5:0] len);
        logic [7:0] hdr;
        hdr = 8'd0;
        hdr[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
        hdr[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
        return hdr;
    endfunction

    // Fold one byte into the running packet parity.
    function automatic logic [7:0] par_update(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload buffer for the transmitter: 64 x 8 register array with a
// synchronous write port and an asynchronous read port. Contents are not reset.
module router_tx_buf
    import router_pkg::*;
(
    input  logic       clk,
    input  logic       we_i,
    input  logic [5:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic [5:0] raddr_i,
    output logic [7:0] rdata_o
);

    logic [7:0] mem_q [0:MAX_LEN];

    // Store an accepted payload byte at the write index.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet transmitter: accepts a command and a payload stream, buffers
// the whole payload, then sends header, payload and parity to the router,
// holding the current byte whenever the router reports busy.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_addr,
    input  logic [5:0]  cmd_len,
    input  logic        cmd_bad_par,
    input  logic        pl_valid,
    output logic        pl_ready,
    input  logic [7:0]  pl_data,
    input  logic        busy,
    output logic [7:0]  pkt_data,
    output logic        pkt_valid,
    output logic        pkt_done,
    output logic        cmd_err,
    output logic [15:0] tx_count
);

    // Last value of the gap counter before returning to IDLE.
    localparam logic [7:0] GAP_LAST = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

    tx_state_t   state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [5:0]  len_q, len_d;
    logic [1:0]  addr_q, addr_d;
    logic        bad_q, bad_d;
    logic [7:0]  par_q, par_d;
    logic [7:0]  gap_q, gap_d;
    logic [15:0] tx_count_q, tx_count_d;
    logic        pkt_done_q, pkt_done_d;
    logic        cmd_err_q, cmd_err_d;
    logic        buf_we;
    logic [7:0]  buf_rdata;
    logic        last_byte;

    router_tx_buf u_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (idx_q),
        .wdata_i (pl_data),
        .raddr_i (idx_q),
        .rdata_o (buf_rdata)
    );

    assign last_byte = (idx_q == (len_q - 6'd1));

    // State, counters, latched command and pulse outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= 6'd0;
            len_q      <= 6'd0;
            addr_q     <= 2'd0;
            bad_q      <= 1'b0;
            par_q      <= 8'd0;
            gap_q      <= 8'd0;
            tx_count_q <= 16'd0;
            pkt_done_q <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            bad_q      <= bad_d;
            par_q      <= par_d;
            gap_q      <= gap_d;
            tx_count_q <= tx_count_d;
            pkt_done_q <= pkt_done_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    // Next-state logic: command intake, payload load, transmit and gap.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        addr_d     = addr_q;
        bad_d      = bad_q;
        par_d      = par_q;
        gap_d      = gap_q;
        tx_count_d = tx_count_q;
        pkt_done_d = 1'b0;
        cmd_err_d  = 1'b0;
        buf_we     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if ((cmd_addr == ADDR_ILLEGAL) || (cmd_len == 6'd0)) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        addr_d  = cmd_addr;
                        len_d   = cmd_len;
                        bad_d   = cmd_bad_par;
                        par_d   = make_header(cmd_addr, cmd_len);
                        idx_d   = 6'd0;
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (pl_valid) begin
                    buf_we = 1'b1;
                    par_d  = par_update(par_q, pl_data);
                    if (last_byte) begin
                        idx_d   = 6'd0;
                        state_d = ST_HEADER;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_HEADER: begin
                if (!busy) begin
                    state_d = ST_PAYLOAD;
                end else begin
                    state_d = ST_HEADER;
                end
            end
            ST_PAYLOAD: begin
                if (!busy) begin
                    if (last_byte) begin
                        idx_d   = 6'd0;
                        state_d = ST_PARITY;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PARITY: begin
                if (!busy) begin
                    pkt_done_d = 1'b1;
                    tx_count_d = tx_count_q + 16'd1;
                    gap_d      = 8'd0;
                    if (GAP_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = 8'd0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 6'd0;
            end
        endcase
    end

    // Pin decode from registered state, index and buffer only.
    always_comb begin
        pkt_data  = 8'd0;
        pkt_valid = 1'b0;
        case (state_q)
            ST_HEADER: begin
                pkt_data  = make_header(addr_q, len_q);
                pkt_valid = 1'b1;
            end
            ST_PAYLOAD: begin
                pkt_data  = buf_rdata;
                pkt_valid = 1'b1;
            end
            ST_PARITY: begin
                pkt_data  = par_q ^ {8{bad_q}};
                pkt_valid = 1'b0;
            end
            default: begin
                pkt_data  = 8'd0;
                pkt_valid = 1'b0;
            end
        endcase
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign pl_ready  = (state_q == ST_LOAD);
    assign pkt_done  = pkt_done_q;
    assign cmd_err   = cmd_err_q;
    assign tx_count  = tx_count_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: a transaction-level model predicts
// the byte stream, counters and pulses; a negedge process compares every cycle.
module tb_router_pkt_tx;

    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_addr = 2'd0;
    logic [5:0]  cmd_len = 6'd0;
    logic        cmd_bad_par = 1'b0;
    logic        pl_valid = 1'b0;
    logic        pl_ready;
    logic [7:0]  pl_data = 8'd0;
    logic        busy = 1'b0;
    logic [7:0]  pkt_data;
    logic        pkt_valid;
    logic        pkt_done;
    logic        cmd_err;
    logic [15:0] tx_count;

    router_pkt_tx #(.GAP_CYCLES(GAP)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .cmd_bad_par (cmd_bad_par),
        .pl_valid    (pl_valid),
        .pl_ready    (pl_ready),
        .pl_data     (pl_data),
        .busy        (busy),
        .pkt_data    (pkt_data),
        .pkt_valid   (pkt_valid),
        .pkt_done    (pkt_done),
        .cmd_err     (cmd_err),
        .tx_count    (tx_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state
    logic [7:0]  exp_q[$];
    logic [7:0]  obs_q[$];
    logic [7:0]  ld_q[$];
    logic        loading = 1'b0;
    logic [1:0]  m_addr = 2'd0;
    logic [5:0]  m_len = 6'd0;
    logic        m_bad = 1'b0;
    logic [7:0]  m_last_par = 8'd0;
    logic [7:0]  m_last_hdr = 8'd0;
    logic [15:0] exp_tx = 16'd0;
    logic        exp_done = 1'b0;
    logic        exp_err = 1'b0;
    int          gap_left = 0;
    bit          chk_en = 1'b0;
    int          cnt_22 = 0;
    int          cnt_err = 0;
    int          cnt_valid = 0;
    int          cnt_plr = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Per-cycle compare followed by prediction of the next edge's effect.
    initial forever begin
        @(negedge clk);
        if (chk_en && !reset) begin
            check("pkt_done", {15'd0, pkt_done}, {15'd0, exp_done});
            check("cmd_err", {15'd0, cmd_err}, {15'd0, exp_err});
            check("tx_count", tx_count, exp_tx);
            check("pl_ready", {15'd0, pl_ready}, {15'd0, loading});
            check("cmd_ready", {15'd0, cmd_ready},
                  {15'd0, (!loading && exp_q.size() == 0 && gap_left == 0)});
            if (exp_q.size() > 1) begin
                check("pkt_valid", {15'd0, pkt_valid}, 16'd1);
                check("pkt_data", {8'd0, pkt_data}, {8'd0, exp_q[0]});
            end else if (exp_q.size() == 1) begin
                check("par_valid", {15'd0, pkt_valid}, 16'd0);
                check("par_data", {8'd0, pkt_data}, {8'd0, exp_q[0]});
            end else begin
                check("idle_valid", {15'd0, pkt_valid}, 16'd0);
            end
            if (pkt_valid && pkt_data == 8'h22) cnt_22++;
            if (cmd_err) cnt_err++;
            if (pkt_valid) cnt_valid++;
            if (pl_ready) cnt_plr++;
        end
        if (reset) begin
            exp_q.delete();
            ld_q.delete();
            loading  = 1'b0;
            exp_tx   = 16'd0;
            exp_done = 1'b0;
            exp_err  = 1'b0;
            gap_left = 0;
        end else begin
            exp_done = 1'b0;
            exp_err  = 1'b0;
            if (gap_left > 0) gap_left--;
            if (exp_q.size() > 0 && !busy) begin
                obs_q.push_back(pkt_data);
                if (exp_q.size() == 1) begin
                    exp_done = 1'b1;
                    exp_tx   = exp_tx + 16'd1;
                    gap_left = GAP;
                end
                void'(exp_q.pop_front());
            end
            if (cmd_valid && cmd_ready) begin
                if (cmd_addr == 2'd3 || cmd_len == 6'd0) begin
                    exp_err = 1'b1;
                end else begin
                    m_addr  = cmd_addr;
                    m_len   = cmd_len;
                    m_bad   = cmd_bad_par;
                    loading = 1'b1;
                    ld_q.delete();
                end
            end
            if (pl_valid && pl_ready) begin
                ld_q.push_back(pl_data);
                if (ld_q.size() == int'(m_len)) begin
                    logic [7:0] hdr;
                    logic [7:0] par;
                    hdr = {m_len, m_addr};
                    par = hdr;
                    exp_q.push_back(hdr);
                    foreach (ld_q[i]) begin
                        par = par ^ ld_q[i];
                        exp_q.push_back(ld_q[i]);
                    end
                    if (m_bad) par = ~par;
                    exp_q.push_back(par);
                    m_last_hdr = hdr;
                    m_last_par = par;
                    loading = 1'b0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_cmd(input logic [1:0] a, input logic [5:0] l, input logic b);
        int k;
        cmd_addr = a;
        cmd_len = l;
        cmd_bad_par = b;
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 200) begin
            tick(1);
            k++;
        end
        if (k >= 200) timeout("cmd_ready_wait");
        tick(1);
        cmd_valid = 1'b0;
    endtask

    task automatic send_pl(input logic [7:0] d);
        int k;
        pl_data = d;
        pl_valid = 1'b1;
        k = 0;
        while (!pl_ready && k < 200) begin
            tick(1);
            k++;
        end
        if (k >= 200) timeout("pl_ready_wait");
        tick(1);
        pl_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || loading || gap_left != 0) && k < 300) begin
            tick(1);
            k++;
        end
        if (k >= 300) timeout("wait_idle");
        tick(1);
    endtask

    task automatic wait_pins(input logic [7:0] d);
        int k;
        k = 0;
        while (!(pkt_valid && pkt_data == d) && k < 100) begin
            tick(1);
            k++;
        end
        if (k >= 100) timeout("wait_pins");
    endtask

    task automatic check_basic_stream(input string name);
        logic [7:0] ref_b [0:4];
        ref_b = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        check({name, "_len"}, 16'(obs_q.size()), 16'd5);
        for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
            check(name, {8'd0, obs_q[i]}, {8'd0, ref_b[i]});
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        check("rst_pkt_valid", {15'd0, pkt_valid}, 16'd0);
        check("rst_pkt_data", {8'd0, pkt_data}, 16'h0000);
        check("rst_cmd_ready", {15'd0, cmd_ready}, 16'd1);
        check("rst_pl_ready", {15'd0, pl_ready}, 16'd0);
        check("rst_tx_count", tx_count, 16'd0);
        chk_en = 1'b1;

        // Basic packet
        obs_q.delete();
        send_cmd(2'd1, 6'd3, 1'b0);
        send_pl(8'h11);
        send_pl(8'h22);
        send_pl(8'h33);
        wait_idle();
        check_basic_stream("basic_stream");
        check("basic_model_par", {8'd0, m_last_par}, 16'h000D);
        check("basic_tx_count", tx_count, 16'd1);

        // Stall during payload
        obs_q.delete();
        send_cmd(2'd1, 6'd3, 1'b0);
        send_pl(8'h11);
        send_pl(8'h22);
        send_pl(8'h33);
        cnt_22 = 0;
        wait_pins(8'h22);
        busy = 1'b1;
        tick(2);
        busy = 1'b0;
        wait_idle();
        check("stall_hold_cycles", 16'(cnt_22), 16'd3);
        check_basic_stream("stall_stream");
        check("stall_tx_count", tx_count, 16'd2);

        // Illegal commands
        cnt_err = 0;
        cnt_valid = 0;
        cnt_plr = 0;
        send_cmd(2'd3, 6'd5, 1'b0);
        send_cmd(2'd0, 6'd0, 1'b0);
        tick(4);
        check("illegal_err_pulses", 16'(cnt_err), 16'd2);
        check("illegal_no_valid", 16'(cnt_valid), 16'd0);
        check("illegal_no_pl_ready", 16'(cnt_plr), 16'd0);
        check("illegal_tx_count", tx_count, 16'd2);

        // Max length with parity inversion
        obs_q.delete();
        send_cmd(2'd2, 6'd63, 1'b1);
        for (int i = 0; i < 63; i++) send_pl(8'(i));
        wait_idle();
        check("max_len", 16'(obs_q.size()), 16'd65);
        check("max_model_hdr", {8'd0, m_last_hdr}, 16'h00FE);
        check("max_model_par", {8'd0, m_last_par}, 16'h003E);
        if (obs_q.size() == 65) begin
            check("max_hdr", {8'd0, obs_q[0]}, 16'h00FE);
            for (int i = 0; i < 63; i++) check("max_payload", {8'd0, obs_q[i+1]}, 16'(i));
            check("max_par", {8'd0, obs_q[64]}, 16'h003E);
        end
        check("max_tx_count", tx_count, 16'd3);

        // Reset mid-packet
        send_cmd(2'd1, 6'd3, 1'b0);
        send_pl(8'h11);
        send_pl(8'h22);
        send_pl(8'h33);
        wait_pins(8'h22);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("midrst_pkt_valid", {15'd0, pkt_valid}, 16'd0);
        check("midrst_tx_count", tx_count, 16'd0);
        check("midrst_cmd_ready", {15'd0, cmd_ready}, 16'd1);
        obs_q.delete();
        send_cmd(2'd0, 6'd1, 1'b0);
        send_pl(8'hA5);
        wait_idle();
        check("post_len", 16'(obs_q.size()), 16'd3);
        if (obs_q.size() == 3) begin
            check("post_hdr", {8'd0, obs_q[0]}, 16'h0004);
            check("post_payload", {8'd0, obs_q[1]}, 16'h00A5);
            check("post_par", {8'd0, obs_q[2]}, 16'h00A1);
        end
        check("post_tx_count", tx_count, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
